// File: rtl/fht_frame_loader_if.sv
// Handshake and RAM-side bus of the FHT frame loader.
// The master side is the loader; the slave side is the sample source, the source RAM and the target RAM.
interface fht_frame_loader_if #(
  parameter int unsigned ADC_WIDTH = 16,
  parameter int unsigned D_BIT     = 22,
  parameter int unsigned A_BIT     = 8,
  parameter int unsigned N_BANK    = 4
);
  logic                    iMODE;
  logic                    iSTART;
  logic                    iVALID;
  logic [ADC_WIDTH-1:0]    iADC_DATA;
  logic                    oREADY;
  logic [A_BIT-1:0]        oADDR_RD;
  logic [N_BANK*D_BIT-1:0] iDATA_RD;
  logic [N_BANK-1:0]       oWE;
  logic [A_BIT-1:0]        oADDR_WR;
  logic [D_BIT-1:0]        oDATA;
  logic                    oFHT_START;
  logic                    oBUSY;
  logic                    oDONE;

  modport master (
    input  iMODE, iSTART, iVALID, iADC_DATA, iDATA_RD,
    output oREADY, oADDR_RD, oWE, oADDR_WR, oDATA, oFHT_START, oBUSY, oDONE
  );

  modport slave (
    output iMODE, iSTART, iVALID, iADC_DATA, iDATA_RD,
    input  oREADY, oADDR_RD, oWE, oADDR_WR, oDATA, oFHT_START, oBUSY, oDONE
  );
endinterface

// File: rtl/fht_frame_loader.sv
// Fills the banked FHT RAM from an ADC stream (LOAD), or copies a bit-reversed frame into
// natural order for the next stage (REORDER), then optionally starts the downstream FHT.
module fht_frame_loader #(
  parameter int unsigned ADC_WIDTH  = 16,
  parameter int unsigned D_BIT      = 22,
  parameter int unsigned A_BIT      = 8,
  parameter int unsigned N_BANK     = 4,
  parameter int unsigned RD_LAT     = 2,
  parameter bit          AUTO_START = 1'b1
) (
  input logic                iCLK,
  input logic                iRESET,
  fht_frame_loader_if.master bus_io
);

  localparam int unsigned BW   = (N_BANK > 1) ? $clog2(N_BANK) : 1;
  localparam int unsigned LW   = $clog2(RD_LAT + 1);
  localparam int unsigned FRAC = D_BIT - ADC_WIDTH;

  localparam logic [BW-1:0]    BLast = BW'(N_BANK - 1);
  localparam logic [A_BIT-1:0] JLast = '1;
  localparam logic [LW-1:0]    LLast = LW'(RD_LAT - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoad    = 3'd1;
  localparam logic [2:0] StRdIssue = 3'd2;
  localparam logic [2:0] StRdWait  = 3'd3;
  localparam logic [2:0] StWr      = 3'd4;
  localparam logic [2:0] StFin     = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [A_BIT-1:0]  j_q, j_d;
  logic [BW-1:0]     b_q, b_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [N_BANK-1:0] ld_we_q, ld_we_d;
  logic [A_BIT-1:0]  ld_addr_q, ld_addr_d;
  logic [D_BIT-1:0]  ld_data_q, ld_data_d;
  logic [D_BIT-1:0]  row_q [N_BANK];
  logic [N_BANK-1:0] b_onehot;
  logic              accept;
  logic              latch;

  function automatic logic [A_BIT-1:0] bitrev(input logic [A_BIT-1:0] v);
    logic [A_BIT-1:0] r;
    for (int i = 0; i < int'(A_BIT); i++) begin
      r[i] = v[A_BIT-1-i];
    end
    return r;
  endfunction

  assign b_onehot = N_BANK'(1) << b_q;
  assign accept   = (state_q == StLoad) && bus_io.iVALID;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    b_d     = b_q;
    lat_d   = lat_q;
    latch   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus_io.iSTART) begin
          j_d     = '0;
          b_d     = '0;
          state_d = bus_io.iMODE ? StRdIssue : StLoad;
        end
      end
      StLoad: begin
        if (accept) begin
          if (b_q == BLast) begin
            b_d = '0;
            j_d = j_q + 1'b1;
            if (j_q == JLast) state_d = StFin;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      StRdIssue: begin
        lat_d   = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (lat_q == LLast) begin
          latch   = 1'b1;
          b_d     = '0;
          state_d = StWr;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StWr: begin
        if (b_q == BLast) begin
          b_d = '0;
          if (j_q == JLast) begin
            state_d = StFin;
          end else begin
            j_d     = j_q + 1'b1;
            state_d = StRdIssue;
          end
        end else begin
          b_d = b_q + 1'b1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // LOAD writes are registered one cycle behind acceptance, so the last one lands in StFin.
  always_comb begin
    ld_we_d   = accept ? b_onehot : '0;
    ld_addr_d = accept ? j_q : ld_addr_q;
    ld_data_d = accept ? (D_BIT'(bus_io.iADC_DATA) << FRAC) : ld_data_q;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q   <= StIdle;
      j_q       <= '0;
      b_q       <= '0;
      lat_q     <= '0;
      ld_we_q   <= '0;
      ld_addr_q <= '0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      b_q       <= b_d;
      lat_q     <= lat_d;
      ld_we_q   <= ld_we_d;
      ld_addr_q <= ld_addr_d;
      ld_data_q <= ld_data_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (latch) begin
      for (int k = 0; k < int'(N_BANK); k++) begin
        row_q[k] <= bus_io.iDATA_RD[k*D_BIT +: D_BIT];
      end
    end
  end

  assign bus_io.oREADY     = (state_q == StLoad);
  assign bus_io.oADDR_RD   = (state_q == StRdIssue) ? bitrev(j_q) : '0;
  assign bus_io.oWE        = (state_q == StWr) ? b_onehot : ld_we_q;
  assign bus_io.oADDR_WR   = (state_q == StWr) ? j_q : ld_addr_q;
  assign bus_io.oDATA      = (state_q == StWr) ? row_q[b_q] : ld_data_q;
  assign bus_io.oDONE      = (state_q == StFin);
  assign bus_io.oFHT_START = (state_q == StFin) && AUTO_START;
  assign bus_io.oBUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_fht_frame_loader.sv
// Directed bench for fht_frame_loader: A_BIT=3, N_BANK=4, RD_LAT=2; DUT a auto-starts, DUT b does not.
module tb_fht_frame_loader;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 22;
  localparam int unsigned AB = 3;
  localparam int unsigned NB = 4;
  localparam int unsigned RL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fht_frame_loader_if #(.ADC_WIDTH(AW), .D_BIT(DW), .A_BIT(AB), .N_BANK(NB)) a_if ();
  fht_frame_loader_if #(.ADC_WIDTH(AW), .D_BIT(DW), .A_BIT(AB), .N_BANK(NB)) b_if ();

  fht_frame_loader #(
    .ADC_WIDTH(AW), .D_BIT(DW), .A_BIT(AB), .N_BANK(NB), .RD_LAT(RL), .AUTO_START(1'b1)
  ) u_dut_a (
    .iCLK   (clk),
    .iRESET (rst),
    .bus_io (a_if.master)
  );

  fht_frame_loader #(
    .ADC_WIDTH(AW), .D_BIT(DW), .A_BIT(AB), .N_BANK(NB), .RD_LAT(RL), .AUTO_START(1'b0)
  ) u_dut_b (
    .iCLK   (clk),
    .iRESET (rst),
    .bus_io (b_if.master)
  );

  // Source RAM: bank b at address a holds a*4+b, read latency of two cycles.
  logic [NB*DW-1:0] rd_p0, rd_p1;

  function automatic logic [NB*DW-1:0] src_row(input logic [AB-1:0] addr);
    logic [NB*DW-1:0] r;
    r = '0;
    for (int bb = 0; bb < int'(NB); bb++) r[bb*DW +: DW] = DW'({addr, 2'(bb)});
    return r;
  endfunction

  always @(posedge clk) begin
    rd_p0 <= src_row(a_if.oADDR_RD);
    rd_p1 <= rd_p0;
  end
  assign a_if.iDATA_RD = rd_p1;
  assign b_if.iDATA_RD = '0;

  // Write monitor.
  logic [DW-1:0] mem_a [NB][8];
  int wr_a = 0, m1_a = 0, hot_a = 0, done_a = 0, fs_a = 0, st_a = 0;
  int wr_b = 0, done_b = 0, fs_b = 0, st_b = 0;

  always @(negedge clk) begin
    if (a_if.oWE != '0) begin
      wr_a <= wr_a + 1;
      if (a_if.oDATA == 22'h3FFFC0) m1_a <= m1_a + 1;
      if (!$onehot(a_if.oWE)) hot_a <= hot_a + 1;
      for (int bb = 0; bb < int'(NB); bb++) begin
        if (a_if.oWE[bb]) mem_a[bb][a_if.oADDR_WR] <= a_if.oDATA;
      end
    end
    if (a_if.oDONE) done_a <= done_a + 1;
    if (a_if.oFHT_START) fs_a <= fs_a + 1;
    if (a_if.iSTART && !a_if.oBUSY) st_a <= cyc;
    if (b_if.oWE != '0) wr_b <= wr_b + 1;
    if (b_if.oDONE) done_b <= done_b + 1;
    if (b_if.oFHT_START) fs_b <= fs_b + 1;
    if (b_if.iSTART && !b_if.oBUSY) st_b <= cyc;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_a(input string tag);
    check({tag, "_ready"}, 64'(a_if.oREADY), 64'd0);
    check({tag, "_addr_rd"}, 64'(a_if.oADDR_RD), 64'd0);
    check({tag, "_we"}, 64'(a_if.oWE), 64'd0);
    check({tag, "_addr_wr"}, 64'(a_if.oADDR_WR), 64'd0);
    check({tag, "_data"}, 64'(a_if.oDATA), 64'd0);
    check({tag, "_fs"}, 64'(a_if.oFHT_START), 64'd0);
    check({tag, "_busy"}, 64'(a_if.oBUSY), 64'd0);
    check({tag, "_done"}, 64'(a_if.oDONE), 64'd0);
  endtask

  task automatic start_a(input logic mode);
    a_if.iSTART = 1'b1;
    a_if.iMODE  = mode;
    @(posedge clk); #1;
    a_if.iSTART = 1'b0;
    a_if.iMODE  = 1'b0;
  endtask

  int wr0, m10;

  initial begin
    a_if.iMODE = 1'b0; a_if.iSTART = 1'b0; a_if.iVALID = 1'b0; a_if.iADC_DATA = '0;
    b_if.iMODE = 1'b0; b_if.iSTART = 1'b0; b_if.iVALID = 1'b0; b_if.iADC_DATA = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_a("rst");
    check("rst_b_busy", 64'(b_if.oBUSY), 64'd0);
    check("rst_b_we", 64'(b_if.oWE), 64'd0);
    rst = 1'b0;

    // Reset in the middle of a LOAD frame.
    start_a(1'b0);
    for (int k = 0; k < 5; k++) begin
      a_if.iVALID = 1'b1; a_if.iADC_DATA = 16'(50 + k);
      @(posedge clk); #1;
    end
    check("mid_busy", 64'(a_if.oBUSY), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle_a("rst1");
    @(posedge clk); #1;
    chk_idle_a("rst2");
    rst = 1'b0;
    a_if.iVALID = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 64'(a_if.oBUSY), 64'd0);
    check("abort_done_cnt", 64'(done_a), 64'd0);
    check("abort_fs_cnt", 64'(fs_a), 64'd0);

    // LOAD ramp 0..31, valid every cycle.
    wr0 = wr_a;
    start_a(1'b0);
    for (int k = 0; k < 32; k++) begin
      a_if.iVALID = 1'b1; a_if.iADC_DATA = 16'(k);
      @(posedge clk); #1;
    end
    a_if.iVALID = 1'b0;
    check("ld_done", 64'(a_if.oDONE), 64'd1);
    check("ld_fs", 64'(a_if.oFHT_START), 64'd1);
    check("ld_lat", 64'(cyc - st_a), 64'd33);
    check("ld_ready_drop", 64'(a_if.oREADY), 64'd0);
    check("ld_last_we", 64'(a_if.oWE), 64'h8);
    check("ld_last_addr", 64'(a_if.oADDR_WR), 64'd7);
    check("ld_last_data", 64'(a_if.oDATA), 64'h7C0);
    @(posedge clk); #1;
    check("ld_idle_busy", 64'(a_if.oBUSY), 64'd0);
    check("ld_idle_we", 64'(a_if.oWE), 64'd0);
    check("ld_s13", 64'(mem_a[1][3]), 64'h340);
    check("ld_s0", 64'(mem_a[0][0]), 64'd0);
    check("ld_s22", 64'(mem_a[2][5]), 64'h580);
    check("ld_wr_cnt", 64'(wr_a - wr0), 64'd32);

    // LOAD with iVALID toggling, data -1.
    wr0 = wr_a; m10 = m1_a;
    start_a(1'b0);
    for (int k = 0; k < 63; k++) begin
      a_if.iVALID = ((k % 2) == 0); a_if.iADC_DATA = '1;
      @(posedge clk); #1;
    end
    a_if.iVALID = 1'b0;
    check("tog_done", 64'(a_if.oDONE), 64'd1);
    check("tog_lat", 64'(cyc - st_a), 64'd64);
    @(posedge clk); #1;
    check("tog_wr_cnt", 64'(wr_a - wr0), 64'd32);
    check("tog_m1_cnt", 64'(m1_a - m10), 64'd32);

    // REORDER, with a stray iSTART while busy.
    wr0 = wr_a;
    a_if.iADC_DATA = '0;
    start_a(1'b1);
    check("ro_addr_rd0", 64'(a_if.oADDR_RD), 64'd0);
    check("ro_issue_we", 64'(a_if.oWE), 64'd0);
    check("ro_ready", 64'(a_if.oREADY), 64'd0);
    repeat (7) @(posedge clk);
    #1;
    check("ro_addr_rd1", 64'(a_if.oADDR_RD), 64'd4);
    @(posedge clk); #1;
    check("ro_wait_we", 64'(a_if.oWE), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("ro_wr_we", 64'(a_if.oWE), 64'h1);
    check("ro_wr_addr", 64'(a_if.oADDR_WR), 64'd1);
    check("ro_wr_data", 64'(a_if.oDATA), 64'd16);
    @(posedge clk); #1;
    start_a(1'b0);
    for (int i = 0; i < 80 && !a_if.oDONE; i++) begin
      @(posedge clk); #1;
    end
    check("ro_done_seen", 64'(a_if.oDONE), 64'd1);
    check("ro_lat", 64'(cyc - st_a), 64'd57);
    check("ro_fin_we", 64'(a_if.oWE), 64'd0);
    check("ro_fs", 64'(a_if.oFHT_START), 64'd1);
    @(posedge clk); #1;
    for (int bb = 0; bb < int'(NB); bb++) begin
      check("ro_row1", 64'(mem_a[bb][1]), 64'(16 + bb));
    end
    check("ro_row3", 64'(mem_a[2][3]), 64'd26);
    check("ro_row6", 64'(mem_a[1][6]), 64'd13);
    check("ro_row7", 64'(mem_a[3][7]), 64'd31);
    check("ro_wr_cnt", 64'(wr_a - wr0), 64'd32);

    // Back-to-back LOAD in the cycle after oDONE's frame ends.
    check("b2b_idle", 64'(a_if.oBUSY), 64'd0);
    start_a(1'b0);
    for (int k = 0; k < 32; k++) begin
      a_if.iVALID = 1'b1; a_if.iADC_DATA = 16'(100 + k);
      @(posedge clk); #1;
    end
    a_if.iVALID = 1'b0;
    check("b2b_done", 64'(a_if.oDONE), 64'd1);
    check("b2b_lat", 64'(cyc - st_a), 64'd33);
    @(posedge clk); #1;
    check("b2b_s0", 64'(mem_a[0][0]), 64'h1900);
    check("b2b_s22", 64'(mem_a[2][5]), 64'h1E80);
    check("b2b_s31", 64'(mem_a[3][7]), 64'h20C0);

    // AUTO_START=0 on DUT b, with an ignored iSTART mid-frame.
    b_if.iSTART = 1'b1; b_if.iMODE = 1'b0;
    @(posedge clk); #1;
    b_if.iSTART = 1'b0;
    for (int k = 0; k < 32; k++) begin
      b_if.iVALID = 1'b1; b_if.iADC_DATA = 16'(200 + k);
      b_if.iSTART = (k == 10); b_if.iMODE = (k == 10);
      @(posedge clk); #1;
    end
    b_if.iVALID = 1'b0; b_if.iSTART = 1'b0; b_if.iMODE = 1'b0;
    check("as0_done", 64'(b_if.oDONE), 64'd1);
    check("as0_fs", 64'(b_if.oFHT_START), 64'd0);
    check("as0_lat", 64'(cyc - st_b), 64'd33);
    @(posedge clk); #1;
    check("as0_idle", 64'(b_if.oBUSY), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("as0_fs_cnt", 64'(fs_b), 64'd0);
    check("as0_done_cnt", 64'(done_b), 64'd1);
    check("as0_wr_cnt", 64'(wr_b), 64'd32);
    check("a_done_cnt", 64'(done_a), 64'd4);
    check("a_fs_cnt", 64'(fs_a), 64'd4);
    check("a_onehot", 64'(hot_a), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
